// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: sequencer for the 2-of-5 column decoder of a
// 5-column LED matrix. Latches a code word, flags codes without exactly
// two ones, and time-multiplexes the columns with a one-cycle blank at
// every column change.
//
// Parameters:
//   DIV        clocks per column dwell (>= 2)
//   BLINK_DIV  frames per blink half-period in ERROR (>= 1, blink only)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   code_in     code word, [4]=E1 .. [0]=E5
//   load        one-cycle strobe capturing code_in
//   clear       return to IDLE, clear latched code
//   code_out    latched code to decoder E1..E5
//   enable      decoder enable (low in blank cycle)
//   col_sel     one-hot column select, [4]=C1 .. [0]=C5
//   code_err    latched code does not have exactly two ones
//   frame_tick  pulse in the last cycle of the C5 dwell
//
// Build option:
//   ERROR_BLINK_EN  when defined, ERROR blinks the decoder enable with
//                   a BLINK_DIV-frame half-period.
//
// All outputs are registered; no input reaches an output combinationally.

module matrix_scan_controller #(
    parameter int DIV       = 1000,
    parameter int BLINK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] code_in,
    input  logic       load,
    input  logic       clear,
    output logic [4:0] code_out,
    output logic       enable,
    output logic [4:0] col_sel,
    output logic       code_err,
    output logic       frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [4:0] COL_FIRST = 5'b10000;
    localparam logic [4:0] COL_LAST  = 5'b00001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          code_ok;
    logic          wrap;
    logic          frame_end;
    logic [CW-1:0] cnt_nxt;
    logic [4:0]    col_nxt;
    logic          tick_nxt;
    logic          lit_ok;

    // Scan datapath: next dwell count and column for a running scan.
    always_comb begin
        code_ok   = ($countones(code_in) == 2);
        wrap      = (cnt == LAST);
        frame_end = wrap && (col_sel == COL_LAST);
        cnt_nxt   = wrap ? '0 : cnt + CW'(1);
        // Right rotate: C5 (bit 0) wraps back to C1 (bit 4).
        col_nxt   = wrap ? {col_sel[0], col_sel[4:1]} : col_sel;
        tick_nxt  = (col_nxt == COL_LAST) && (cnt_nxt == LAST);
    end

`ifdef ERROR_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FLAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frm_cnt;
    logic          blink_on;
    logic [FW-1:0] frm_nxt;
    logic          blink_nxt;

    // Blink phase only advances while scanning in ERROR; the frame
    // counter toggles the phase after BLINK_DIV completed frames.
    always_comb begin
        frm_nxt   = frm_cnt;
        blink_nxt = blink_on;
        if (state == ERROR && frame_end) begin
            if (frm_cnt == FLAST) begin
                frm_nxt   = '0;
                blink_nxt = ~blink_on;
            end else begin
                frm_nxt = frm_cnt + FW'(1);
            end
        end
        lit_ok = blink_nxt;
    end
`else
    always_comb begin
        lit_ok = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            // clear also wins over a simultaneous load.
            state      <= IDLE;
            code_out   <= '0;
            code_err   <= 1'b0;
            col_sel    <= '0;
            cnt        <= '0;
            enable     <= 1'b0;
            frame_tick <= 1'b0;
`ifdef ERROR_BLINK_EN
            frm_cnt    <= '0;
            blink_on   <= 1'b1;
`endif
        end else if (load) begin
            // Any load restarts the frame at C1, blank cycle first.
            state      <= code_ok ? SCAN : ERROR;
            code_out   <= code_in;
            code_err   <= ~code_ok;
            col_sel    <= COL_FIRST;
            cnt        <= '0;
            enable     <= 1'b0;
            frame_tick <= 1'b0;
`ifdef ERROR_BLINK_EN
            frm_cnt    <= '0;
            blink_on   <= 1'b1;
`endif
        end else begin
            case (state)
                SCAN, ERROR: begin
                    cnt        <= cnt_nxt;
                    col_sel    <= col_nxt;
                    enable     <= (cnt_nxt != '0) && lit_ok;
                    frame_tick <= tick_nxt;
`ifdef ERROR_BLINK_EN
                    frm_cnt    <= frm_nxt;
                    blink_on   <= blink_nxt;
`endif
                end
                IDLE: begin
                    cnt        <= '0;
                    col_sel    <= '0;
                    enable     <= 1'b0;
                    frame_tick <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    code_out   <= '0;
                    code_err   <= 1'b0;
                    col_sel    <= '0;
                    cnt        <= '0;
                    enable     <= 1'b0;
                    frame_tick <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: load-vector table plus hand-written
// corner sequences, checked cycle by cycle against a frame-position model.

module tb_matrix_scan_controller;

    localparam int DIV       = 4;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = 5 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       clear;
    logic [4:0] code_in;
    logic [4:0] code_out;
    logic       enable;
    logic [4:0] col_sel;
    logic       code_err;
    logic       frame_tick;

    matrix_scan_controller #(
        .DIV       (DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .load       (load),
        .clear      (clear),
        .code_out   (code_out),
        .enable     (enable),
        .col_sel    (col_sel),
        .code_err   (code_err),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] code;
        logic       en;
        logic [4:0] col;
        logic       err;
        logic       ft;
    } exp_t;

    typedef struct {
        logic [4:0] code;
        logic       err;
        int         hold;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    // Model: 0 IDLE, 1 SCAN, 2 ERROR; age = cycles since the load edge.
    int         m_state = 0;
    int         m_age   = 0;
    logic [4:0] m_code  = '0;

    function automatic int ones(input logic [4:0] v);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   dwell;
        int   colix;
        logic on;
        e = '0;
        if (m_state != 0) begin
            dwell = m_age % DIV;
            colix = (m_age / DIV) % 5;
            on    = 1'b1;
`ifdef ERROR_BLINK_EN
            if (m_state == 2)
                on = (((m_age / FRAME) / BLINK_DIV) % 2) == 0;
`endif
            e.code = m_code;
            e.err  = (m_state == 2);
            e.col  = 5'b10000 >> colix;
            e.en   = (dwell != 0) && on;
            e.ft   = (m_age % FRAME) == FRAME - 1;
        end
        return e;
    endfunction

    task automatic model_update(input logic r, input logic ld,
                                input logic cl, input logic [4:0] ci);
        if (r || cl) begin
            m_state = 0;
            m_code  = '0;
            m_age   = 0;
        end else if (ld) begin
            m_code  = ci;
            m_state = (ones(ci) == 2) ? 1 : 2;
            m_age   = 0;
        end else if (m_state != 0) begin
            m_age++;
        end
    endtask

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b",
                     name, $time, act, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic ld, input logic cl,
                        input logic [4:0] ci);
        exp_t e;
        reset   = r;
        load    = ld;
        clear   = cl;
        code_in = ci;
        model_update(r, ld, cl, ci);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("code_out",   code_out,          e.code);
        chk("enable",     {4'b0, enable},    {4'b0, e.en});
        chk("col_sel",    col_sel,           e.col);
        chk("code_err",   {4'b0, code_err},  {4'b0, e.err});
        chk("frame_tick", {4'b0, frame_tick}, {4'b0, e.ft});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'($urandom));
    endtask

    initial begin
        vecs[0] = '{5'b11000, 1'b0, FRAME * 2 + 5};
        vecs[1] = '{5'b11100, 1'b1, FRAME + 3};
        vecs[2] = '{5'b00101, 1'b0, FRAME + 1};
        vecs[3] = '{5'b00000, 1'b1, DIV + 2};
        vecs[4] = '{5'b11111, 1'b1, DIV + 2};
        vecs[5] = '{5'b10001, 1'b0, FRAME};
        vecs[6] = '{5'b01010, 1'b0, 7};
        vecs[7] = '{5'b00011, 1'b0, FRAME - 1};
        vecs[8] = '{5'b10110, 1'b1, 9};
        vecs[9] = '{5'b00001, 1'b1, 6};

        reset   = 1'b1;
        load    = 1'b0;
        clear   = 1'b0;
        code_in = '0;

        // Reset state, with a load strobe that must be ignored.
        step(1'b1, 1'b0, 1'b0, 5'b00000);
        step(1'b1, 1'b1, 1'b0, 5'b11000);
        chk("rst_col", col_sel, 5'b00000);
        chk("rst_code", code_out, 5'b00000);
        run(3);

        // Table of loads: error flag and full scan behaviour.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, vecs[i].code);
            chk("vec_err", {4'b0, code_err}, {4'b0, vecs[i].err});
            chk("vec_code", code_out, vecs[i].code);
            chk("vec_col", col_sel, 5'b10000);
            run(vecs[i].hold);
        end

        // Reload mid-dwell at C4 restarts at C1 with a blank cycle.
        step(1'b0, 1'b1, 1'b0, 5'b11000);
        run(3 * DIV + 1);
        chk("mid_c4", col_sel, 5'b00010);
        step(1'b0, 1'b1, 1'b0, 5'b00101);
        chk("reload_col", col_sel, 5'b10000);
        chk("reload_en", {4'b0, enable}, 5'b0);
        chk("reload_err", {4'b0, code_err}, 5'b0);
        run(DIV + 2);

        // clear beats a simultaneous load.
        step(1'b0, 1'b1, 1'b1, 5'b11100);
        chk("clr_code", code_out, 5'b00000);
        chk("clr_col", col_sel, 5'b00000);
        chk("clr_en", {4'b0, enable}, 5'b0);
        run(5);

        // Reset mid-frame in ERROR, load in the same cycle ignored.
        step(1'b0, 1'b1, 1'b0, 5'b11100);
        run(2 * FRAME + 7);
        step(1'b1, 1'b1, 1'b0, 5'b11000);
        chk("rst_mid_col", col_sel, 5'b00000);
        chk("rst_mid_err", {4'b0, code_err}, 5'b0);
        chk("rst_mid_code", code_out, 5'b00000);
        chk("rst_mid_ft", {4'b0, frame_tick}, 5'b0);
        run(3);

        // Long ERROR run covering the blink half-periods when enabled.
        step(1'b0, 1'b1, 1'b0, 5'b01110);
        run(6 * FRAME + 3);

        // Back to SCAN from ERROR.
        step(1'b0, 1'b1, 1'b0, 5'b01001);
        run(FRAME + 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
